picorv_pcpi_hub: RTL
====================

# picorv_pcpi_hub

Multi-channel PCPI dispatcher between the PicoRV core's PCPI port and up to NCH coprocessors. Qualifies core requests on operand/writeback readiness, then registers and broadcasts the instruction and operands to all enabled channels. It arbitrates the first claiming channel and returns a registered single-cycle response to the core. Unclaimed instructions are trapped after a programmable timeout.

## Interface

Parameters:
- XLEN, 32, data/address width
- ILEN, 32, instruction width
- NCH, 4, coprocessor channel count (1..16)
- PCPI_RS3, 0, when 1, rs3 is forwarded and its valid flag gates dispatch; when 0, rs3 is ignored and forwarded as zero
- TIMEOUT, 16, cycles to wait for a claim; 0 disables the timeout

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_valid  in  1  core PCPI request
- core_insn  in  ILEN  instruction
- core_prefix  in  16  instruction prefix
- core_pc  in  XLEN  instruction PC
- core_rs1_valid / core_rs2_valid / core_rs3_valid  in  1 each  operand valid flags
- core_rs1_data / core_rs2_data / core_rs3_data  in  XLEN each  operands
- core_wb_valid  in  1  writeback slot available
- core_ready  out  1  response strobe
- core_wb_write  out  1  writeback request
- core_wb_data  out  XLEN  writeback data
- core_br_enable  out  1  branch request
- core_br_nextpc  out  XLEN  branch target
- core_trap  out  1  unclaimed-instruction trap, valid with core_ready
- ch_enable  in  NCH  per-channel enable
- ch_valid  out  NCH  per-channel request
- ch_insn  out  ILEN  registered broadcast instruction
- ch_prefix  out  16  registered broadcast prefix
- ch_pc  out  XLEN  registered broadcast PC
- ch_rs1_data / ch_rs2_data / ch_rs3_data  out  XLEN each  registered broadcast operands
- ch_ready  in  NCH  per-channel claim
- ch_wb_write  in  NCH  per-channel writeback request
- ch_wb_data  in  NCH*XLEN  per-channel writeback data; channel k occupies bits [k*XLEN +: XLEN]
- ch_br_enable  in  NCH  per-channel branch request
- ch_br_nextpc  in  NCH*XLEN  per-channel branch target; channel k occupies bits [k*XLEN +: XLEN]
- busy  out  1  high in any state other than IDLE
- last_ch  out  4  index of the most recent claiming channel
- collision  out  1  sticky flag: two or more enabled channels claimed in the same cycle

## Operation

- FSM states: IDLE, WAIT, RESP.
- Dispatch condition, go = core_valid & core_rs1_valid & core_rs2_valid & core_wb_valid & (core_rs3_valid | !PCPI_RS3).
- IDLE:
  - On go, latch insn, prefix, pc and operands into the ch_* registers (rs3 latched as 0 when PCPI_RS3=0).
  - Clear the timeout counter and go to WAIT.
  - core_valid without go is ignored.
- WAIT:
  - ch_valid = ch_enable, masked combinationally every cycle.
  - Claim vector = ch_ready & ch_enable. If nonzero, the lowest set index k wins:
    - Register wb_write[k], wb_data[k], br_enable[k] and br_nextpc[k] into the response registers.
    - Set last_ch=k and trap=0.
    - If more than one bit is set, set collision.
    - Go to RESP.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter equals TIMEOUT-1 in a cycle with no claim:
    - Register wb_write=0, br_enable=0, data=0 and trap=1.
    - Go to RESP.
  - Counter width is $clog2(TIMEOUT+1), minimum 1; it never wraps.
- RESP:
  - core_ready=1 for exactly one cycle, driving the response registers; ch_valid=0.
  - Return to IDLE unconditionally.
- Response gating: core_wb_write, core_wb_data, core_br_enable, core_br_nextpc and core_trap are forced to 0 whenever core_ready=0.
- ch_enable changes during WAIT take effect the same cycle. If every channel is disabled, only the timeout can end the transaction (with TIMEOUT=0 it waits until reset).
- ch_* data outputs hold their last latched values outside WAIT.

## Timing

- Reset values:
  - State IDLE.
  - ch_valid=0, core_ready=0, busy=0, last_ch=0, collision=0, counter=0.
  - All response registers and ch_* data registers 0.
- Reset mid-transaction aborts it in the same edge: no core_ready is issued and ch_valid drops the next cycle.
- Cycle timing, with go sampled at edge N:
  - ch_valid is high from cycle N+1.
  - A claim sampled at edge M (M ≥ N+1) gives core_ready=1 in cycle M+1.
  - Minimum request-to-ready latency is 2 cycles.
- Timeout: with no claim, core_ready=1 and core_trap=1 in cycle N+TIMEOUT+1.
- The hub re-samples core_valid only in IDLE, so there is at least one idle cycle between consecutive dispatches. The core must drop core_valid in the cycle after core_ready.
- A claim arriving in the same cycle the counter hits TIMEOUT-1 wins over the timeout.
- Channels must treat ch_valid as level-sensitive and hold ch_ready for at most the cycle in which they deliver results.

## Test plan

- NCH=4, TIMEOUT=16. go with insn=0x0200_00B3, rs1=5, rs2=7; ch2 asserts ready 3 cycles later with wb_write=1, wb_data=35 → core_ready exactly one cycle, core_wb_data=35, last_ch=2, core_trap=0, ch_valid=0 in RESP.
- core_valid=1 with core_rs2_valid=0 for 5 cycles, then core_rs2_valid=1 → ch_valid stays 0 until the cycle after rs2 is valid; latched rs2 equals the value present at go.
- ch1 and ch3 claim simultaneously, ch1 with br_enable=1 and br_nextpc=0x100 → ch1's response is returned, core_br_nextpc=0x100, collision=1 and stays 1 until reset.
- No channel claims with TIMEOUT=16 → core_ready=1 and core_trap=1 exactly 17 cycles after go, all other response outputs 0. Repeat with a claim exactly at the timeout edge → normal response, core_trap=0.
- ch_enable=4'b0100 while ch0 asserts ready → ch0 ignored and ch_valid[0]=0; ch2 claim accepted.
- Reset asserted in WAIT → no core_ready issued; all outputs at reset values the next cycle; a new go 2 cycles later completes normally.

Source files
------------

// File: rtl/picorv_pcpi_hub.sv
// picorv_pcpi_hub: multi-channel PCPI dispatcher.
//
// Takes one PCPI request from the PicoRV core, waits until its operands and the
// writeback slot are ready, then registers the instruction and operands and
// broadcasts them to every enabled coprocessor channel. The lowest-numbered
// channel that claims supplies the response. The response is registered and
// returned to the core as a single-cycle core_ready strobe. If nobody claims
// within TIMEOUT cycles, the core gets a trap response instead.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   core_*  (in)          PCPI request: valid, insn, prefix, pc, operand
//                         valid/data pairs, and writeback slot availability
//   core_*  (out)         response: ready strobe, wb_write/wb_data,
//                         br_enable/br_nextpc, trap (all zero unless ready)
//   ch_enable, ch_ready,
//   ch_wb_*, ch_br_* (in) per-channel enable, claim and result; the packed data
//                         buses hold channel k in bits [k*XLEN +: XLEN]
//   ch_valid (out)        per-channel request (ch_enable while waiting)
//   ch_insn..ch_rs3_data  registered broadcast of the dispatched instruction
//   busy                  transaction in flight
//   last_ch               index of the most recent claiming channel
//   collision             sticky: several enabled channels claimed together
module picorv_pcpi_hub #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ILEN     = 32,
  parameter int unsigned NCH      = 4,
  parameter bit          PCPI_RS3 = 1'b0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                core_valid,
  input  logic [ILEN-1:0]     core_insn,
  input  logic [15:0]         core_prefix,
  input  logic [XLEN-1:0]     core_pc,
  input  logic                core_rs1_valid,
  input  logic [XLEN-1:0]     core_rs1_data,
  input  logic                core_rs2_valid,
  input  logic [XLEN-1:0]     core_rs2_data,
  input  logic                core_rs3_valid,
  input  logic [XLEN-1:0]     core_rs3_data,
  input  logic                core_wb_valid,
  output logic                core_ready,
  output logic                core_wb_write,
  output logic [XLEN-1:0]     core_wb_data,
  output logic                core_br_enable,
  output logic [XLEN-1:0]     core_br_nextpc,
  output logic                core_trap,

  input  logic [NCH-1:0]      ch_enable,
  output logic [NCH-1:0]      ch_valid,
  output logic [ILEN-1:0]     ch_insn,
  output logic [15:0]         ch_prefix,
  output logic [XLEN-1:0]     ch_pc,
  output logic [XLEN-1:0]     ch_rs1_data,
  output logic [XLEN-1:0]     ch_rs2_data,
  output logic [XLEN-1:0]     ch_rs3_data,
  input  logic [NCH-1:0]      ch_ready,
  input  logic [NCH-1:0]      ch_wb_write,
  input  logic [NCH*XLEN-1:0] ch_wb_data,
  input  logic [NCH-1:0]      ch_br_enable,
  input  logic [NCH*XLEN-1:0] ch_br_nextpc,

  output logic                busy,
  output logic [3:0]          last_ch,
  output logic                collision
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TimeoutEn = (TIMEOUT != 0);
  // Counter value in the last waiting cycle before the trap fires.
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [ILEN-1:0] insn_q;
  logic [15:0]     prefix_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, rs3_q;

  logic            resp_wb_write_q;
  logic [XLEN-1:0] resp_wb_data_q;
  logic            resp_br_enable_q;
  logic [XLEN-1:0] resp_br_nextpc_q;
  logic            resp_trap_q;
  logic [3:0]      last_ch_q;
  logic            collision_q;

  logic            go;
  logic            latch_req;
  logic            take_claim;
  logic            take_timeout;

  logic [NCH-1:0]  claim;
  logic            multi_claim;
  logic [3:0]      win_idx;
  logic            win_wb_write;
  logic [XLEN-1:0] win_wb_data;
  logic            win_br_enable;
  logic [XLEN-1:0] win_br_nextpc;

  assign go = core_valid & core_rs1_valid & core_rs2_valid & core_wb_valid &
              (core_rs3_valid | !PCPI_RS3);

  // Lowest-index claiming channel wins; scan from the top so the lowest
  // index is the last assignment.
  always_comb begin
    claim         = ch_ready & ch_enable;
    win_idx       = '0;
    win_wb_write  = 1'b0;
    win_wb_data   = '0;
    win_br_enable = 1'b0;
    win_br_nextpc = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (claim[i]) begin
        win_idx       = 4'(i);
        win_wb_write  = ch_wb_write[i];
        win_wb_data   = ch_wb_data[i*XLEN +: XLEN];
        win_br_enable = ch_br_enable[i];
        win_br_nextpc = ch_br_nextpc[i*XLEN +: XLEN];
      end
    end
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi_claim = |(claim & (claim - NCH'(1)));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_req    = 1'b0;
    take_claim   = 1'b0;
    take_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          latch_req = 1'b1;
          cnt_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (|claim) begin
          take_claim = 1'b1;
          state_d    = StResp;
        end else begin
          if (TimeoutEn && (cnt_q == CntLast)) begin
            take_timeout = 1'b1;
            state_d      = StResp;
          end
          // Saturate rather than wrap; matters only with the timeout disabled.
          if (!(&cnt_q)) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      insn_q           <= '0;
      prefix_q         <= '0;
      pc_q             <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      rs3_q            <= '0;
      resp_wb_write_q  <= 1'b0;
      resp_wb_data_q   <= '0;
      resp_br_enable_q <= 1'b0;
      resp_br_nextpc_q <= '0;
      resp_trap_q      <= 1'b0;
      last_ch_q        <= '0;
      collision_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        insn_q   <= core_insn;
        prefix_q <= core_prefix;
        pc_q     <= core_pc;
        rs1_q    <= core_rs1_data;
        rs2_q    <= core_rs2_data;
        rs3_q    <= PCPI_RS3 ? core_rs3_data : '0;
      end
      if (take_claim) begin
        resp_wb_write_q  <= win_wb_write;
        resp_wb_data_q   <= win_wb_data;
        resp_br_enable_q <= win_br_enable;
        resp_br_nextpc_q <= win_br_nextpc;
        resp_trap_q      <= 1'b0;
        last_ch_q        <= win_idx;
        if (multi_claim) begin
          collision_q <= 1'b1;
        end
      end else if (take_timeout) begin
        resp_wb_write_q  <= 1'b0;
        resp_wb_data_q   <= '0;
        resp_br_enable_q <= 1'b0;
        resp_br_nextpc_q <= '0;
        resp_trap_q      <= 1'b1;
      end
    end
  end

  // Enable is applied combinationally so a channel dropped mid-wait stops
  // seeing the request in that same cycle.
  assign ch_valid    = (state_q == StWait) ? ch_enable : '0;
  assign ch_insn     = insn_q;
  assign ch_prefix   = prefix_q;
  assign ch_pc       = pc_q;
  assign ch_rs1_data = rs1_q;
  assign ch_rs2_data = rs2_q;
  assign ch_rs3_data = rs3_q;

  assign core_ready     = (state_q == StResp);
  assign core_wb_write  = core_ready & resp_wb_write_q;
  assign core_wb_data   = core_ready ? resp_wb_data_q : '0;
  assign core_br_enable = core_ready & resp_br_enable_q;
  assign core_br_nextpc = core_ready ? resp_br_nextpc_q : '0;
  assign core_trap      = core_ready & resp_trap_q;

  assign busy      = (state_q != StIdle);
  assign last_ch   = last_ch_q;
  assign collision = collision_q;

endmodule
